hdb3_vb_insert: RTL and testbench

//  Upstream stage of the HDB3 encoder. Takes the serial NRZ bit stream and replaces each run of
//  RUN_LEN zeros with 000V or B00V (HDB3 substitution rules). Emits 2-bit symbol codes that feed
//  the polarity-assignment stage directly: 00 = zero, 01 = mark, 10 = B, 11 = V.

---
 rtl/hdb3_pkg.sv | 13 +
 rtl/hdb3_code_shifter.sv | 39 +++
 rtl/hdb3_vb_insert.sv | 89 ++++++++
 tb/tb_hdb3_vb_insert.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared HDB3 symbol definitions used by the substitution, polarity and decode stages.
package hdb3_pkg;

    typedef logic [1:0] hdb3_code_t;

    localparam hdb3_code_t CODE_ZERO = 2'b00;
    localparam hdb3_code_t CODE_MARK = 2'b01;
    localparam hdb3_code_t CODE_B    = 2'b10;
    localparam hdb3_code_t CODE_V    = 2'b11;

    localparam int HDB3_RUN_LEN = 4;

endpackage

// File: rtl/hdb3_code_shifter.sv
// Enabled 2-bit symbol shift register. The last stage can be overwritten on a
// shift edge so a B can replace the first zero of a run as it reaches the output.
module hdb3_code_shifter
    import hdb3_pkg::*;
#(
    parameter int DEPTH = HDB3_RUN_LEN
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_shift_en,
    input  logic [1:0] i_code_in,
    input  logic       i_ovr_last,
    input  logic [1:0] i_ovr_code,
    output logic [1:0] o_code_last
);

    hdb3_code_t r_stage [DEPTH];

    // Shift on enable; the final stage takes the overwrite code when requested.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= CODE_ZERO;
            end
        end else if (i_shift_en) begin
            r_stage[0] <= i_code_in;
            for (int i = 1; i < DEPTH; i++) begin
                if ((i == DEPTH - 1) && i_ovr_last) begin
                    r_stage[i] <= i_ovr_code;
                end else begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end
    end

    assign o_code_last = r_stage[DEPTH-1];

endmodule

// File: rtl/hdb3_vb_insert.sv
// HDB3 substitution stage: classifies each incoming NRZ bit as zero/mark/B/V.
// A completed run of RUN_LEN zeros ends in V; when an even number of marks has
// been sent since the last V, the run's first zero becomes B (B00V), else 000V.
// The pipeline depth equals RUN_LEN so the first zero is still correctable.
module hdb3_vb_insert
    import hdb3_pkg::*;
#(
    parameter int RUN_LEN = HDB3_RUN_LEN
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit_en,
    input  logic       i_data_in,
    output logic [1:0] o_code_out,
    output logic       o_code_valid
);

    localparam int CNT_W = $clog2(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

    logic [CNT_W-1:0] r_zero_cnt;
    logic [CNT_W-1:0] r_fill;
    logic             r_mark_par;
    logic             r_code_valid;

    logic             w_run_done;
    logic             w_ins_b;
    hdb3_code_t       w_in_code;

    // Classify the sampled bit and decide whether the run's first zero becomes B.
    always_comb begin
        w_run_done = 1'b0;
        w_ins_b    = 1'b0;
        w_in_code  = CODE_ZERO;
        if (i_data_in) begin
            w_in_code = CODE_MARK;
        end else if (r_zero_cnt == CNT_LAST) begin
            w_run_done = 1'b1;
            w_in_code  = CODE_V;
            w_ins_b    = ~r_mark_par;
        end
    end

    // Run length, mark parity since last V, and pipeline fill tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero_cnt <= '0;
            r_mark_par <= 1'b0;
            r_fill     <= '0;
        end else if (i_bit_en) begin
            if (i_data_in) begin
                r_zero_cnt <= '0;
                r_mark_par <= ~r_mark_par;
            end else if (w_run_done) begin
                r_zero_cnt <= '0;
                r_mark_par <= 1'b0;
            end else begin
                r_zero_cnt <= r_zero_cnt + 1'b1;
            end
            if (r_fill != CNT_LAST) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Valid pulses only for shifts that push a real sampled bit to the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code_valid <= 1'b0;
        end else begin
            r_code_valid <= i_bit_en && (r_fill == CNT_LAST);
        end
    end

    hdb3_code_shifter #(
        .DEPTH (RUN_LEN)
    ) u_shifter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_shift_en  (i_bit_en),
        .i_code_in   (w_in_code),
        .i_ovr_last  (w_ins_b),
        .i_ovr_code  (CODE_B),
        .o_code_last (o_code_out)
    );

    assign o_code_valid = r_code_valid;

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// Directed bench for the HDB3 V/B substitution stage.
module tb_hdb3_vb_insert;
    import hdb3_pkg::*;

    localparam int RL = 4;

    logic       clk;
    logic       i_rst_n;
    logic       i_bit_en;
    logic       i_data_in;
    logic [1:0] o_code_out;
    logic       o_code_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic       seq_bits[$];
    hdb3_code_t seq_exp[$];
    hdb3_code_t got[$];
    int         gaps[8] = '{2, 0, 3, 1, 0, 2, 1, 0};

    hdb3_vb_insert #(.RUN_LEN(RL)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_bit_en     (i_bit_en),
        .i_data_in    (i_data_in),
        .o_code_out   (o_code_out),
        .o_code_valid (o_code_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic d);
        i_bit_en  = en;
        i_data_in = d;
        @(posedge clk);
        #1;
        if (o_code_valid) got.push_back(o_code_out);
    endtask

    task automatic do_reset();
        i_bit_en  = 1'b0;
        i_data_in = 1'b0;
        i_rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", 32'(o_code_out), 32'(CODE_ZERO));
        check("rst_valid", 32'(o_code_valid), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Feed seq_bits plus RL-1 flushing zeros, then compare captured valid codes.
    task automatic run_seq(input string tag, input bit gapped);
        int gi;
        logic b;
        logic [1:0] prev;
        gi = 0;
        got.delete();
        for (int i = 0; i < seq_bits.size() + RL - 1; i++) begin
            b = (i < seq_bits.size()) ? seq_bits[i] : 1'b0;
            if (gapped) begin
                prev = o_code_out;
                for (int j = 0; j < gaps[gi % 8]; j++) begin
                    step(1'b0, 1'b1);
                    check({tag, "_hold"}, 32'(o_code_out), 32'(prev));
                    check({tag, "_gapvalid"}, 32'(o_code_valid), 32'd0);
                end
                gi++;
            end
            step(1'b1, b);
        end
        i_bit_en = 1'b0;
        check({tag, "_count"}, 32'(got.size()), 32'(seq_exp.size()));
        for (int i = 0; i < seq_exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(seq_exp[i]));
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_bit_en  = 1'b0;
        i_data_in = 1'b0;

        // Reset state and priming: first three enables never flag valid.
        do_reset();
        for (int i = 0; i < RL - 1; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("prime_valid[%0d]", i), 32'(o_code_valid), 32'd0);
        end
        step(1'b0, 1'b0);

        // Odd parity at the run: 000V.
        do_reset();
        seq_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_MARK, CODE_ZERO, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("odd_000v", 1'b0);

        // Even parity at the run: B00V.
        do_reset();
        seq_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_MARK, CODE_MARK, CODE_B, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("even_b00v", 1'b0);

        // Eight zeros split into two substitutions; parity clears after each V.
        do_reset();
        seq_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_B, CODE_ZERO, CODE_ZERO, CODE_V, CODE_B, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("zeros8", 1'b0);

        // Mark after three zeros restarts the count; two marks -> even -> B00V.
        do_reset();
        seq_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_MARK, CODE_ZERO, CODE_ZERO, CODE_ZERO, CODE_MARK,
                     CODE_B, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("split_even", 1'b0);

        // Same with a leading mark: three marks -> odd -> 000V.
        do_reset();
        seq_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_MARK, CODE_MARK, CODE_ZERO, CODE_ZERO, CODE_ZERO, CODE_MARK,
                     CODE_ZERO, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("split_odd", 1'b0);

        // Even-parity case with enable gaps; output holds through gaps.
        do_reset();
        seq_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_MARK, CODE_MARK, CODE_B, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("gapped", 1'b1);

        // Reset in the middle of a zero run discards the partial run.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        i_bit_en = 1'b0;
        i_rst_n  = 1'b0;
        #1;
        check("midrst_code", 32'(o_code_out), 32'(CODE_ZERO));
        check("midrst_valid", 32'(o_code_valid), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        seq_bits = '{1'b0, 1'b0, 1'b0, 1'b0};
        seq_exp  = '{CODE_B, CODE_ZERO, CODE_ZERO, CODE_V};
        run_seq("midrst", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
